// File: rtl/rf_wb_ctrl_pkg.sv
// Shared constants for the integer register-file writeback controller:
// register count, the hardwired-zero index and the requester encoding.
package rf_wb_ctrl_pkg;

   localparam int unsigned NUM_REGS = 32;
   localparam int unsigned RF_ZERO  = 0;

   // Requester slots on the shared write port.
   localparam int unsigned REQ_EXU = 0;
   localparam int unsigned REQ_LSU = 1;
   localparam int unsigned NUM_REQ = 2;

endpackage

// File: rtl/rf_wb_ctrl_rr_arb2.sv
// Two-way round-robin arbiter. ready_o depends only on the other slot's valid
// and the priority pointer; grant_o is the one-hot set of completed handshakes.
module rr_arb2
   import rf_wb_ctrl_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_REQ-1:0] valid_i,
   output logic [NUM_REQ-1:0] ready_o,
   output logic [NUM_REQ-1:0] grant_o
);

   // Set when LSU held the port most recently; EXU wins the first tie.
   logic last_lsu;

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path infers a latch.
      ready_o = '0;
      if (!rst) begin
         ready_o[REQ_EXU] = !valid_i[REQ_LSU] || last_lsu;
         ready_o[REQ_LSU] = !valid_i[REQ_EXU] || !last_lsu;
      end
   end

   assign grant_o = valid_i & ready_o;

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      if (rst) begin
         last_lsu <= 1'b1;
      end else if (grant_o[REQ_LSU]) begin
         last_lsu <= 1'b1;
      end else if (grant_o[REQ_EXU]) begin
         last_lsu <= 1'b0;
      end
   end

endmodule

// File: rtl/rf_wb_ctrl.sv
// Register-file writeback controller: arbitrates EXU/LSU onto the single write
// port through one output register and keeps a busy-bit scoreboard for decode.
module rf_wb_ctrl
   import rf_wb_ctrl_pkg::*;
#(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 64
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  issue_valid,
   input  logic [ADDR_WIDTH-1:0] issue_rd,
   output logic                  issue_ready,
   input  logic [ADDR_WIDTH-1:0] rs1_addr,
   input  logic [ADDR_WIDTH-1:0] rs2_addr,
   output logic                  rs1_busy,
   output logic                  rs2_busy,
   input  logic                  exu_valid,
   input  logic [ADDR_WIDTH-1:0] exu_rd,
   input  logic [DATA_WIDTH-1:0] exu_data,
   output logic                  exu_ready,
   input  logic                  lsu_valid,
   input  logic [ADDR_WIDTH-1:0] lsu_rd,
   input  logic [DATA_WIDTH-1:0] lsu_data,
   output logic                  lsu_ready,
   output logic                  rf_wen,
   output logic [ADDR_WIDTH-1:0] rf_waddr,
   output logic [DATA_WIDTH-1:0] rf_wdata
);

   localparam int                    NUM_ENTRIES = 1 << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] ZERO_RD     = ADDR_WIDTH'(RF_ZERO);

   logic [NUM_ENTRIES-1:0] busy;
   logic [NUM_ENTRIES-1:0] busy_next;
   logic [NUM_REQ-1:0]     req_valid;
   logic [NUM_REQ-1:0]     req_ready;
   logic [NUM_REQ-1:0]     req_grant;
   logic                   issue_fire;
   logic                   wb_fire;
   logic                   wb_commit;
   logic [ADDR_WIDTH-1:0]  wb_rd;
   logic [DATA_WIDTH-1:0]  wb_data;

   // ---------------- arbitration ----------------
   assign req_valid[REQ_EXU] = exu_valid;
   assign req_valid[REQ_LSU] = lsu_valid;

   rr_arb2 u_arb (
      .clk     (clk),
      .rst     (rst),
      .valid_i (req_valid),
      .ready_o (req_ready),
      .grant_o (req_grant)
   );

   assign exu_ready = req_ready[REQ_EXU];
   assign lsu_ready = req_ready[REQ_LSU];

   assign wb_fire   = |req_grant;
   assign wb_rd     = req_grant[REQ_LSU] ? lsu_rd   : exu_rd;
   assign wb_data   = req_grant[REQ_LSU] ? lsu_data : exu_data;
   // Writes to x0 complete the handshake but never reach the register file.
   assign wb_commit = wb_fire && (wb_rd != ZERO_RD);

   // ---------------- scoreboard ----------------
   assign rs1_busy    = busy[rs1_addr];
   assign rs2_busy    = busy[rs2_addr];
   assign issue_ready = !busy[issue_rd];
   assign issue_fire  = issue_valid && issue_ready && (issue_rd != ZERO_RD);

   // Clear first, then set: an issue to a register retiring this cycle stays busy.
   always_comb begin
      busy_next = busy;
      if (rf_wen) begin
         busy_next[rf_waddr] = 1'b0;
      end
      if (issue_fire) begin
         busy_next[issue_rd] = 1'b1;
      end
      busy_next[RF_ZERO] = 1'b0;
   end

   always_ff @(posedge clk) begin
      // NOTE: busy is an array of flops that gates issue, so it must be reset, unlike RAM storage.
      if (rst) begin
         busy <= '0;
      end else begin
         busy <= busy_next;
      end
   end

   // ---------------- output stage ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         rf_wen   <= 1'b0;
         rf_waddr <= '0;
         rf_wdata <= '0;
      end else begin
         rf_wen <= wb_commit;
         if (wb_commit) begin
            rf_waddr <= wb_rd;
            rf_wdata <= wb_data;
         end
      end
   end

endmodule
